n64_cfg: RTL and testbench

N64-facing command/configuration register block: the requesting end of the configuration command channel whose responding end is the on-board CPU. It decodes halfword accesses from the N64 PI bus into a small 32-bit register file. It issues commands with arguments to the CPU through a request/busy handshake and exposes the CPU's results and status back to the N64. It sits between the PI bus decoder and the CPU-side configuration logic.

---
 rtl/n64_cfg_pkg.sv | 22 ++
 rtl/n64_cfg.sv | 153 +++++++++++++++
 tb/tb_n64_cfg.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/n64_cfg_pkg.sv
// Shared definitions for the N64-facing configuration register block:
// register offsets, status bit positions, command FSM states and default ID.
package n64_cfg_pkg;

  localparam logic [3:0] REG_STATUS = 4'h0;
  localparam logic [3:0] REG_DATA0  = 4'h4;
  localparam logic [3:0] REG_DATA1  = 4'h8;
  localparam logic [3:0] REG_ID     = 4'hC;

  localparam int STATUS_BUSY_BIT  = 31;
  localparam int STATUS_ERROR_BIT = 30;
  localparam int STATUS_READY_BIT = 29;

  localparam logic [31:0] DEFAULT_IDENTIFIER = 32'h53437632;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    EXECUTE = 2'd2
  } e_cfg_state;

endpackage

// File: rtl/n64_cfg.sv
// N64 PI-side command/configuration register file: halfword bus decode with
// tear-free 32-bit access, plus the request/busy command handshake to the CPU.
module n64_cfg
  import n64_cfg_pkg::*;
#(
  parameter logic [31:0] IDENTIFIER = DEFAULT_IDENTIFIER
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        n64_request,
  input  logic        n64_write,
  input  logic [3:0]  n64_address,
  input  logic [15:0] n64_wdata,
  output logic        n64_ack,
  output logic [15:0] n64_rdata,
  input  logic        cpu_ready,
  input  logic        cpu_busy,
  input  logic [1:0]  data_write,
  input  logic [31:0] wdata,
  output logic        cmd_request,
  output logic [7:0]  cmd,
  output logic [31:0] data0,
  output logic [31:0] data1
);

  e_cfg_state  state;
  e_cfg_state  state_next;
  logic        error;
  logic [15:0] holding;
  logic [31:0] snapshot;
  logic [31:0] status_value;
  logic [31:0] read_value;
  logic [31:0] commit_value;
  logic [3:0]  reg_offset;
  logic        upper_half;
  logic        bus_read;
  logic        bus_write;
  logic        commit;
  logic        cmd_commit;
  logic        data0_commit;
  logic        data1_commit;
  logic        state_idle;
  logic        address_unused;

  assign address_unused = n64_address[0];
  assign reg_offset     = {n64_address[3:2], 2'b00};
  assign upper_half     = ~n64_address[1];
  assign bus_read       = n64_request & ~n64_write;
  assign bus_write      = n64_request & n64_write;
  assign commit         = bus_write & n64_address[1];
  assign commit_value   = {holding, n64_wdata};
  assign cmd_commit     = commit && (reg_offset == REG_STATUS);
  assign data0_commit   = commit && (reg_offset == REG_DATA0);
  assign data1_commit   = commit && (reg_offset == REG_DATA1);
  assign state_idle     = (state == IDLE);

  always_comb begin
    status_value                   = '0;
    status_value[STATUS_BUSY_BIT]  = ~state_idle;
    status_value[STATUS_ERROR_BIT] = error;
    status_value[STATUS_READY_BIT] = cpu_ready;
  end

  always_comb begin
    read_value = '0;
    case (reg_offset)
      REG_STATUS: read_value = status_value;
      REG_DATA0:  read_value = data0;
      REG_DATA1:  read_value = data1;
      REG_ID:     read_value = IDENTIFIER;
      default:    read_value = '0;
    endcase
  end

  // Upper-half accesses stage the other half (holding / snapshot) so the
  // N64 always sees and commits whole 32-bit values.
  always_ff @(posedge clk) begin
    if (reset) begin
      n64_ack   <= 1'b0;
      n64_rdata <= '0;
      holding   <= '0;
      snapshot  <= '0;
    end else begin
      n64_ack <= n64_request;
      if (bus_read) begin
        if (upper_half) begin
          n64_rdata <= read_value[31:16];
          snapshot  <= read_value;
        end else begin
          n64_rdata <= snapshot[15:0];
        end
      end
      if (bus_write && upper_half) begin
        holding <= n64_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_commit && cpu_ready) state_next = REQUEST;
      REQUEST: if (cpu_busy) state_next = EXECUTE;
      EXECUTE: if (!cpu_busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_request = (state == REQUEST);
  end

  // Commits outside IDLE are dropped and flagged; CPU loads override N64 commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      error <= 1'b0;
      cmd   <= '0;
      data0 <= '0;
      data1 <= '0;
    end else begin
      if (cmd_commit) begin
        if (state_idle && cpu_ready) begin
          cmd   <= commit_value[7:0];
          error <= 1'b0;
        end else begin
          error <= 1'b1;
        end
      end
      if ((data0_commit || data1_commit) && !state_idle) begin
        error <= 1'b1;
      end
      if (data_write[0]) begin
        data0 <= wdata;
      end else if (data0_commit && state_idle) begin
        data0 <= commit_value;
      end
      if (data_write[1]) begin
        data1 <= wdata;
      end else if (data1_commit && state_idle) begin
        data1 <= commit_value;
      end
    end
  end

endmodule

// File: tb/tb_n64_cfg.sv
// Bench for n64_cfg: directed scenarios plus random bus/CPU traffic, all
// checked cycle by cycle against a register-level reference model.
module tb_n64_cfg;

  localparam logic [31:0] ID_VALUE = 32'h53437632;

  logic        clk;
  logic        reset;
  logic        n64_request;
  logic        n64_write;
  logic [3:0]  n64_address;
  logic [15:0] n64_wdata;
  logic        n64_ack;
  logic [15:0] n64_rdata;
  logic        cpu_ready;
  logic        cpu_busy;
  logic [1:0]  data_write;
  logic [31:0] wdata;
  logic        cmd_request;
  logic [7:0]  cmd;
  logic [31:0] data0;
  logic [31:0] data1;

  int compared   = 0;
  int mismatched = 0;
  int req_cycles = 0;

  // Reference model: phase 0 = no command, 1 = waiting for CPU, 2 = CPU working
  logic        m_ack;
  logic [15:0] m_rdata;
  logic [15:0] m_hold;
  logic [31:0] m_snap;
  logic        m_err;
  logic [7:0]  m_cmd;
  logic [31:0] m_d0;
  logic [31:0] m_d1;
  int          m_phase;

  n64_cfg dut (
    .clk         (clk),
    .reset       (reset),
    .n64_request (n64_request),
    .n64_write   (n64_write),
    .n64_address (n64_address),
    .n64_wdata   (n64_wdata),
    .n64_ack     (n64_ack),
    .n64_rdata   (n64_rdata),
    .cpu_ready   (cpu_ready),
    .cpu_busy    (cpu_busy),
    .data_write  (data_write),
    .wdata       (wdata),
    .cmd_request (cmd_request),
    .cmd         (cmd),
    .data0       (data0),
    .data1       (data1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic clockCycle();
    logic        n_ack;
    logic [15:0] n_rdata, n_hold;
    logic [31:0] n_snap, n_d0, n_d1, status, val, nv;
    logic        n_err, upper;
    logic [7:0]  n_cmd;
    int          n_phase, idx;
    n_ack = 1'b0; n_rdata = m_rdata; n_hold = m_hold; n_snap = m_snap;
    n_err = m_err; n_cmd = m_cmd; n_d0 = m_d0; n_d1 = m_d1; n_phase = m_phase;
    if (reset) begin
      n_rdata = '0; n_hold = '0; n_snap = '0; n_err = 1'b0;
      n_cmd = '0; n_d0 = '0; n_d1 = '0; n_phase = 0;
    end else begin
      status = '0;
      status[31] = (m_phase != 0);
      status[30] = m_err;
      status[29] = cpu_ready;
      idx   = int'(n64_address[3:2]);
      upper = !n64_address[1];
      n_ack = n64_request;
      if (n64_request && !n64_write) begin
        case (idx)
          0: val = status;
          1: val = m_d0;
          2: val = m_d1;
          default: val = ID_VALUE;
        endcase
        if (upper) begin
          n_rdata = val[31:16];
          n_snap  = val;
        end else begin
          n_rdata = m_snap[15:0];
        end
      end
      if (n64_request && n64_write) begin
        if (upper) begin
          n_hold = n64_wdata;
        end else begin
          nv = {m_hold, n64_wdata};
          if (idx == 0) begin
            if (m_phase == 0 && cpu_ready) begin
              n_cmd = nv[7:0]; n_err = 1'b0; n_phase = 1;
            end else begin
              n_err = 1'b1;
            end
          end else if (idx == 1 || idx == 2) begin
            if (m_phase != 0) n_err = 1'b1;
            else if (idx == 1) n_d0 = nv;
            else n_d1 = nv;
          end
        end
      end
      if (m_phase == 1 && cpu_busy) n_phase = 2;
      else if (m_phase == 2 && !cpu_busy) n_phase = 0;
      if (data_write[0]) n_d0 = wdata;
      if (data_write[1]) n_d1 = wdata;
    end
    @(posedge clk);
    #1;
    m_ack = n_ack; m_rdata = n_rdata; m_hold = n_hold; m_snap = n_snap;
    m_err = n_err; m_cmd = n_cmd; m_d0 = n_d0; m_d1 = n_d1; m_phase = n_phase;
    if (cmd_request === 1'b1) req_cycles++;
    checkOutput("ack", 32'(n64_ack), 32'(m_ack));
    if (m_ack) checkOutput("rdata", 32'(n64_rdata), 32'(m_rdata));
    checkOutput("cmd_request", 32'(cmd_request), 32'(m_phase == 1));
    checkOutput("cmd", 32'(cmd), 32'(m_cmd));
    checkOutput("data0", data0, m_d0);
    checkOutput("data1", data1, m_d1);
  endtask

  // One bus access: request cycle, then the ack cycle with the bus idle.
  task automatic applyStimulus(input logic wr, input logic [3:0] addr,
                               input logic [15:0] wd, output logic [15:0] rd);
    n64_request = 1'b1;
    n64_write   = wr;
    n64_address = addr;
    n64_wdata   = wd;
    clockCycle();
    rd = n64_rdata;
    n64_request = 1'b0;
    n64_write   = 1'b0;
    clockCycle();
  endtask

  task automatic readReg(input logic [3:0] base, output logic [31:0] v);
    logic [15:0] hi, lo;
    applyStimulus(1'b0, base, 16'h0, hi);
    applyStimulus(1'b0, base | 4'h2, 16'h0, lo);
    v = {hi, lo};
  endtask

  task automatic writeReg(input logic [3:0] base, input logic [31:0] v);
    logic [15:0] rd;
    applyStimulus(1'b1, base, v[31:16], rd);
    applyStimulus(1'b1, base | 4'h2, v[15:0], rd);
  endtask

  initial begin
    logic [15:0] rd;
    logic [31:0] v, saved;
    m_ack = 0; m_rdata = 0; m_hold = 0; m_snap = 0; m_err = 0;
    m_cmd = 0; m_d0 = 0; m_d1 = 0; m_phase = 0;
    reset = 1'b1; n64_request = 1'b0; n64_write = 1'b0; n64_address = 4'h0;
    n64_wdata = 16'h0; cpu_ready = 1'b1; cpu_busy = 1'b0; data_write = 2'b00;
    wdata = 32'h0;
    clockCycle();
    clockCycle();
    reset = 1'b0;
    clockCycle();

    $display("[TB] ID register");
    applyStimulus(1'b0, 4'hC, 16'h0, rd);
    checkOutput("id_upper", 32'(rd), 32'h5343);
    applyStimulus(1'b0, 4'hE, 16'h0, rd);
    checkOutput("id_lower", 32'(rd), 32'h7632);

    $display("[TB] DATA0 round trip");
    writeReg(4'h4, 32'hDEADBEEF);
    checkOutput("data0_write", data0, 32'hDEADBEEF);
    readReg(4'h4, v);
    checkOutput("data0_readback", v, 32'hDEADBEEF);

    $display("[TB] command handshake");
    req_cycles = 0;
    applyStimulus(1'b1, 4'h2, 16'h0052, rd);
    clockCycle();
    cpu_busy = 1'b1;
    clockCycle();
    checkOutput("cmd_code", 32'(cmd), 32'h52);
    data_write = 2'b01;
    wdata = 32'h12345678;
    clockCycle();
    data_write = 2'b00;
    cpu_busy = 1'b0;
    clockCycle();
    clockCycle();
    checkOutput("cmd_request_cycles", 32'(req_cycles), 32'd3);
    readReg(4'h0, v);
    checkOutput("status_done", v, 32'h20000000);
    readReg(4'h4, v);
    checkOutput("data0_from_cpu", v, 32'h12345678);

    $display("[TB] command while not ready");
    cpu_ready = 1'b0;
    req_cycles = 0;
    writeReg(4'h0, 32'h00000011);
    readReg(4'h0, v);
    checkOutput("status_not_ready", v, 32'h40000000);
    checkOutput("no_request_when_not_ready", 32'(req_cycles), 32'd0);

    $display("[TB] DATA1 commit during execute");
    cpu_ready = 1'b1;
    writeReg(4'h0, 32'h00000033);
    cpu_busy = 1'b1;
    clockCycle();
    clockCycle();
    saved = data1;
    writeReg(4'h8, 32'hCAFEF00D);
    checkOutput("data1_unchanged", data1, saved);
    readReg(4'h0, v);
    checkOutput("status_exec_error", v, 32'hE0000000);
    cpu_busy = 1'b0;
    clockCycle();
    clockCycle();
    writeReg(4'h0, 32'h00000044);
    readReg(4'h0, v);
    checkOutput("status_error_cleared", v, 32'hA0000000);
    cpu_busy = 1'b1;
    clockCycle();
    cpu_busy = 1'b0;
    clockCycle();
    clockCycle();

    $display("[TB] tear-free read");
    writeReg(4'h4, 32'h01020304);
    applyStimulus(1'b0, 4'h4, 16'h0, rd);
    checkOutput("tear_upper", 32'(rd), 32'h0102);
    data_write = 2'b01;
    wdata = 32'hAAAA5555;
    clockCycle();
    data_write = 2'b00;
    applyStimulus(1'b0, 4'h6, 16'h0, rd);
    checkOutput("tear_lower", 32'(rd), 32'h0304);
    checkOutput("tear_data0", data0, 32'hAAAA5555);

    $display("[TB] CPU write wins over N64 commit");
    applyStimulus(1'b1, 4'h4, 16'h1111, rd);
    data_write = 2'b01;
    wdata = 32'h77778888;
    applyStimulus(1'b1, 4'h6, 16'h2222, rd);
    data_write = 2'b00;
    checkOutput("cpu_wins", data0, 32'h77778888);

    $display("[TB] reset during request");
    writeReg(4'h0, 32'h00000055);
    reset = 1'b1;
    clockCycle();
    reset = 1'b0;
    checkOutput("reset_request", 32'(cmd_request), 32'd0);
    checkOutput("reset_data0", data0, 32'h0);
    checkOutput("reset_data1", data1, 32'h0);
    readReg(4'h0, v);
    checkOutput("reset_status", v, 32'h20000000);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      cpu_ready  = ($urandom_range(0, 3) != 0);
      cpu_busy   = 1'($urandom_range(0, 1));
      data_write = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      wdata      = $urandom;
      if ($urandom_range(0, 63) == 0) begin
        reset = 1'b1;
        clockCycle();
        reset = 1'b0;
      end
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    16'($urandom_range(0, 65535)), rd);
    end
    data_write = 2'b00;
    cpu_busy = 1'b0;
    clockCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
